div_hilo_ctrl: RTL

Sequencer between the EX stage and the 32-cycle unsigned restoring divider. It accepts DIV/DIVU requests, converts signed operands to magnitudes, and holds the divider's `start` through the full run. It then sign-corrects the divider's `{remainder, quotient}` result and writes it into the architectural HI/LO registers. It also serves MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO, and supplies the pipeline stall (`busy`).

---
 rtl/div_hilo_ctrl_if.sv | 29 ++
 rtl/div_hilo_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/div_hilo_ctrl_if.sv
// EX-stage side of the HI/LO divide sequencer: request, MTHI/MTLO writes,
// architectural HI/LO and the stall/complete status.
interface div_hilo_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             req;
    logic             req_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    // Pipeline side drives requests and consumes HI/LO and status.
    modport master (
        output req, req_signed, op_a, op_b, flush, mthi, mtlo, wdata,
        input  hi, lo, busy, done
    );

    modport slave (
        input  req, req_signed, op_a, op_b, flush, mthi, mtlo, wdata,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/div_hilo_ctrl.sv
// DIV/DIVU sequencer in front of a 32-cycle unsigned restoring divider; owns HI/LO.
// Optional DIV_ZERO_BYPASS_EN: zero divisors complete in one cycle without the divider.
module div_hilo_ctrl #(
    parameter int WIDTH = 32  // the attached divider is fixed at 32 bits
) (
    input  logic               clock,
    input  logic               reset,
    div_hilo_ctrl_if.slave     ex,
    output logic [WIDTH-1:0]   o_div_dividend,
    output logic [WIDTH-1:0]   o_div_divisor,
    output logic               o_div_start,
    input  logic [2*WIDTH-1:0] i_div_z,
    input  logic               i_div_busy,
    input  logic               i_div_ready
);

`ifdef DIV_ZERO_BYPASS_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_ZERO} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN} state_t;
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic             r_start;
    logic             r_busy;
    logic             r_done;
    logic             r_neg_q;
    logic             r_neg_r;
`ifdef DIV_ZERO_BYPASS_EN
    logic [WIDTH-1:0] r_zero_a;
    logic             w_b_zero;
`endif

    logic             w_accept;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_div_q;
    logic [WIDTH-1:0] w_div_r;
    logic [WIDTH-1:0] w_lo_fix;
    logic [WIDTH-1:0] w_hi_fix;

    assign w_accept = ex.req & ~ex.flush;
    assign w_a_neg  = ex.req_signed & ex.op_a[WIDTH-1];
    assign w_b_neg  = ex.req_signed & ex.op_b[WIDTH-1];
    // Two's-complement negate wraps, so -2^31 keeps its bit pattern as a magnitude.
    assign w_mag_a  = w_a_neg ? -ex.op_a : ex.op_a;
    assign w_mag_b  = w_b_neg ? -ex.op_b : ex.op_b;

    assign w_div_q  = i_div_z[WIDTH-1:0];
    assign w_div_r  = i_div_z[2*WIDTH-1:WIDTH];
    assign w_lo_fix = r_neg_q ? -w_div_q : w_div_q;
    assign w_hi_fix = r_neg_r ? -w_div_r : w_div_r;

`ifdef DIV_ZERO_BYPASS_EN
    assign w_b_zero = (ex.op_b == '0);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_hi       <= '0;
            r_lo       <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
            r_zero_a   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // MTHI/MTLO land even on an accept edge; the divide result overwrites later.
                    if (ex.mthi) r_hi <= ex.wdata;
                    if (ex.mtlo) r_lo <= ex.wdata;
                    if (w_accept) begin
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_dividend <= w_mag_a;
                        r_divisor  <= w_mag_b;
                        r_busy     <= 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
                        r_zero_a   <= ex.op_a;
                        if (w_b_zero) begin
                            r_state <= S_ZERO;
                        end else begin
                            r_start <= 1'b1;
                            r_state <= S_RUN;
                        end
`else
                        r_start    <= 1'b1;
                        r_state    <= S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    if (ex.flush) begin
                        r_start <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (i_div_ready) begin
                        // start is still high on this edge, which is what clears the divider.
                        r_lo    <= w_lo_fix;
                        r_hi    <= w_hi_fix;
                        r_start <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
`ifdef DIV_ZERO_BYPASS_EN
                S_ZERO: begin
                    if (ex.flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_hi    <= r_zero_a;
                        r_lo    <= '1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
`endif
                default: begin
                    r_start <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ex.hi          = r_hi;
    assign ex.lo          = r_lo;
    assign ex.busy        = r_busy;
    assign ex.done        = r_done;
    assign o_div_dividend = r_dividend;
    assign o_div_divisor  = r_divisor;
    assign o_div_start    = r_start;

    a_busy_done_excl: assert property (@(posedge clock) disable iff (reset)
        !(r_busy && r_done));

    // The divider reports ready only while its run is still marked busy.
    a_ready_in_run: assert property (@(posedge clock) disable iff (reset)
        (r_state == S_RUN && i_div_ready) |-> i_div_busy);

endmodule
